// File: rtl/imem_loader.sv
// Byte-stream program loader for the core's instruction memory: length-prefixed, XOR-checksummed.
// Define IMEM_LOADER_ZERO_FILL_EN to NOP-fill the unloaded tail of memory after a good load.
module imem_loader #(
    parameter int unsigned MEM_BYTES      = 1024,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        core_reset_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [1:0]  err_code_o,
    output logic [15:0] words_loaded_o
);

    localparam int unsigned MAX_WORDS = MEM_BYTES / 4;

    localparam logic [1:0] ErrLen  = 2'b01;
    localparam logic [1:0] ErrCsum = 2'b10;
    localparam logic [1:0] ErrTmo  = 2'b11;

`ifdef IMEM_LOADER_ZERO_FILL_EN
    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);
`endif

    typedef enum logic [3:0] {
        StIdle, StLen0, StLen1, StData, StWrite, StCsum, StFill, StDone, StErr
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] words_q, words_d;
    logic [7:0]  csum_q, csum_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] word_q, word_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] idle_q, idle_d;
    logic [1:0]  err_q, err_d;
    logic        accept;
    logic        timeout;
`ifdef IMEM_LOADER_ZERO_FILL_EN
    logic [31:0] fill_start;
`endif

    always_comb begin
        rx_ready_o = (state_q == StLen0) || (state_q == StLen1) ||
                     (state_q == StData) || (state_q == StCsum);
        accept     = rx_ready_o && rx_valid_i;
        timeout    = rx_ready_o && !accept && ((idle_q + 32'd1) >= TIMEOUT_CYCLES);
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        words_d    = words_q;
        csum_d     = csum_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        idle_d     = idle_q;
        err_d      = err_q;
`ifdef IMEM_LOADER_ZERO_FILL_EN
        fill_start = 32'(BASE_ADDR) + {14'd0, count_q, 2'b00};
`endif

        if (rx_ready_o) begin
            idle_d = accept ? 32'd0 : idle_q + 32'd1;
        end
        if (accept) begin
            csum_d = csum_q ^ rx_data_i;
        end

        case (state_q)
            StIdle, StDone, StErr: begin
                if (start_i) begin
                    state_d    = StLen0;
                    count_d    = '0;
                    words_d    = '0;
                    csum_d     = '0;
                    byte_idx_d = '0;
                    idle_d     = '0;
                    err_d      = '0;
                end
            end
            StLen0: begin
                if (accept) begin
                    count_d[7:0] = rx_data_i;
                    state_d      = StLen1;
                end
            end
            StLen1: begin
                if (accept) begin
                    count_d = {rx_data_i, count_q[7:0]};
                    if (32'(count_d) > MAX_WORDS) begin
                        state_d = StErr;
                        err_d   = ErrLen;
                    end else if (count_d == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    word_d[{byte_idx_q, 3'b000} +: 8] = rx_data_i;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Latch address/data now so they are stable for the whole write cycle.
                        wdata_d = {rx_data_i, word_q[23:0]};
                        addr_d  = 32'(BASE_ADDR) + {14'd0, words_q, 2'b00};
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                words_d = words_q + 16'd1;
                state_d = (words_d == count_q) ? StCsum : StData;
            end
            StCsum: begin
                if (accept) begin
                    if (rx_data_i == csum_q) begin
`ifdef IMEM_LOADER_ZERO_FILL_EN
                        if (fill_start <= LAST_ADDR) begin
                            state_d = StFill;
                            addr_d  = fill_start;
                            wdata_d = '0;
                        end else begin
                            state_d = StDone;
                        end
`else
                        state_d = StDone;
`endif
                    end else begin
                        state_d = StErr;
                        err_d   = ErrCsum;
                    end
                end
            end
`ifdef IMEM_LOADER_ZERO_FILL_EN
            StFill: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = StDone;
                end else begin
                    addr_d = addr_q + 32'd4;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        if (timeout) begin
            state_d = StErr;
            err_d   = ErrTmo;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            count_q    <= '0;
            words_q    <= '0;
            csum_q     <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            idle_q     <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            words_q    <= words_d;
            csum_q     <= csum_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            idle_q     <= idle_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        mem_we_o       = (state_q == StWrite) || (state_q == StFill);
        mem_addr_o     = addr_q;
        mem_wdata_o    = wdata_q;
        core_reset_o   = (state_q != StDone);
        busy_o         = (state_q != StIdle) && (state_q != StDone) && (state_q != StErr);
        done_o         = (state_q == StDone);
        error_o        = (state_q == StErr);
        err_code_o     = err_q;
        words_loaded_o = words_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; build with IMEM_LOADER_ZERO_FILL_EN for the fill case.
module tb_imem_loader;

`ifdef IMEM_LOADER_ZERO_FILL_EN
    localparam int unsigned MemB = 32;
`else
    localparam int unsigned MemB = 1024;
`endif

    logic        clk, rst_n, start, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready, mem_we, core_reset, busy, done, error;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  err_code;
    logic [15:0] words_loaded;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    imem_loader #(
        .MEM_BYTES      (MemB),
        .BASE_ADDR      (0),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .rx_data_i      (rx_data),
        .rx_valid_i     (rx_valid),
        .rx_ready_o     (rx_ready),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .core_reset_o   (core_reset),
        .busy_o         (busy),
        .done_o         (done),
        .error_o        (error),
        .err_code_o     (err_code),
        .words_loaded_o (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check_eq("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        log_addr.delete();
        log_data.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_log(input string tag, input int idx, input logic [31:0] a,
                             input logic [31:0] d);
        check_eq({tag, "_addr"}, (idx < log_addr.size()) ? log_addr[idx] : 32'hDEAD_BEEF, a);
        check_eq({tag, "_data"}, (idx < log_data.size()) ? log_data[idx] : 32'hDEAD_BEEF, d);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check_eq({tag, "_mem_addr"}, mem_addr, 32'd0);
        check_eq({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check_eq({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_error"}, 32'(error), 32'd0);
        check_eq({tag, "_err_code"}, 32'(err_code), 32'd0);
        check_eq({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    logic [7:0]  one_word[7] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h10, 8'h20, 8'h30};
    logic [31:0] prog[11] = '{32'h20100001, 32'h20110000, 32'h20120001, 32'h02308020,
                              32'h22310001, 32'h2252FFFF, 32'h1640FFFC, 32'h00000000,
                              32'h20130005, 32'h20160002, 32'h20170309};

    initial begin
        logic [7:0]  cs;
        logic [31:0] w;
        int          n;

        rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #3;
        check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifndef IMEM_LOADER_ZERO_FILL_EN
        // Single word, including write latency after the fourth data byte.
        pulse_start();
        check_eq("sw_busy", 32'(busy), 32'd1);
        check_eq("sw_core_reset_loading", 32'(core_reset), 32'd1);
        for (int i = 0; i < 6; i++) send_byte(one_word[i]);
        check_eq("sw_we_latency", 32'(mem_we), 32'd1);
        check_eq("sw_addr_live", mem_addr, 32'h0);
        check_eq("sw_wdata_live", mem_wdata, 32'h20100001);
        send_byte(one_word[6]);
        check_eq("sw_done", 32'(done), 32'd1);
        check_eq("sw_core_reset", 32'(core_reset), 32'd0);
        check_eq("sw_busy_end", 32'(busy), 32'd0);
        check_eq("sw_words", 32'(words_loaded), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check_eq("sw_done_held", 32'(done), 32'd1);
        check_eq("sw_nwrites", 32'(log_addr.size()), 32'd1);
        check_log("sw_w0", 0, 32'h0, 32'h20100001);

        // Eleven-word program with random valid gaps, restarted from DONE.
        @(negedge clk);
        pulse_start();
        check_eq("restart_done_clr", 32'(done), 32'd0);
        check_eq("restart_core_reset", 32'(core_reset), 32'd1);
        send_byte(8'h0B);
        send_byte(8'h00);
        cs = 8'h0B;
        for (int i = 0; i < 11; i++) begin
            w = prog[i];
            for (int k = 0; k < 4; k++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send_byte(w[8*k +: 8]);
                cs = cs ^ w[8*k +: 8];
            end
        end
        send_byte(cs);
        @(negedge clk);
        #1;
        check_eq("sum_done", 32'(done), 32'd1);
        check_eq("sum_words", 32'(words_loaded), 32'd11);
        check_eq("sum_nwrites", 32'(log_addr.size()), 32'd11);
        for (int i = 0; i < 11; i++) check_log($sformatf("sum_w%0d", i), i, 32'(4 * i), prog[i]);
        @(negedge clk);

        // Oversize length: 257 words.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        check_eq("big_error", 32'(error), 32'd1);
        check_eq("big_code", 32'(err_code), 32'd1);
        check_eq("big_rx_ready", 32'(rx_ready), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check_eq("big_nwrites", 32'(log_addr.size()), 32'd0);
        @(negedge clk);
`else
        // Zero fill of the remainder of a 32-byte memory.
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(one_word[i]);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("fill_done", 32'(done), 32'd1);
        check_eq("fill_words", 32'(words_loaded), 32'd1);
        #1;
        check_eq("fill_nwrites", 32'(log_addr.size()), 32'd8);
        check_log("fill_w0", 0, 32'h0, 32'h20100001);
        for (int i = 1; i < 8; i++) check_log($sformatf("fill_w%0d", i), i, 32'(4 * i), 32'h0);
        @(negedge clk);
`endif

        // Bad checksum: the word is still written.
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(one_word[i]);
        send_byte(8'h31);
        check_eq("bad_error", 32'(error), 32'd1);
        check_eq("bad_code", 32'(err_code), 32'd2);
        check_eq("bad_core_reset", 32'(core_reset), 32'd1);
        check_eq("bad_done", 32'(done), 32'd0);
        #1;
        check_eq("bad_nwrites", 32'(log_addr.size()), 32'd1);
        check_log("bad_w0", 0, 32'h0, 32'h20100001);
        @(negedge clk);

        // Timeout after two data bytes: error on the 16th idle cycle.
        pulse_start();
        check_eq("tmo_error_clr", 32'(error), 32'd0);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        n = 0;
        while (!error && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("tmo_cycles", 32'(n), 32'd16);
        check_eq("tmo_code", 32'(err_code), 32'd3);
        @(negedge clk);

        // Asynchronous abort mid-DATA.
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("abort_nwrites", 32'(log_addr.size()), 32'd0);
        check_eq("abort_idle_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
